// File: rtl/gcbp_line_reader_pkg.sv
// gcbp_line_reader_pkg: constants shared with the line generator,
// FSM state type, tagged buffer entry and bit-reverse helper.
package gcbp_line_reader_pkg;

  localparam int C_SUBIMAGE_WIDTH     = 128;
  localparam int C_NUM_HORI_SUBIMAGES = 4;
  localparam int C_LINES_PER_SUBIMAGE = 128;
  localparam int C_BRAM_ADDR_BITS     = 9;
  localparam int C_SUB_BITS           = 2;
  localparam int C_LINE_BITS          = 7;

  localparam logic [C_BRAM_ADDR_BITS-1:0] C_LAST_ADDR =
    C_BRAM_ADDR_BITS'(C_NUM_HORI_SUBIMAGES * C_LINES_PER_SUBIMAGE - 1);

  typedef logic [C_SUBIMAGE_WIDTH-1:0] gcbp_word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  typedef struct packed {
    gcbp_word_t             data;
    logic [C_SUB_BITS-1:0]  sub;
    logic [C_LINE_BITS-1:0] line;
    logic                   last;
  } entry_t;

  function automatic gcbp_word_t bit_rev(input gcbp_word_t d);
    gcbp_word_t r;
    r = '0;
    for (int i = 0; i < C_SUBIMAGE_WIDTH; i++)
      r[i] = d[C_SUBIMAGE_WIDTH-1-i];
    return r;
  endfunction

endpackage

// File: rtl/gcbp_rd_fifo2.sv
// gcbp_rd_fifo2: two-entry tagged line buffer.
// Ports: i_wr/i_wr_entry push, i_rd pop, o_rd_entry head, o_occ count.
module gcbp_rd_fifo2
  import gcbp_line_reader_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic       i_wr,
  input  entry_t     i_wr_entry,
  input  logic       i_rd,
  output entry_t     o_rd_entry,
  output logic [1:0] o_occ
);

  entry_t     mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] occ_q;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (i_wr) begin
        mem_q[wr_ptr_q] <= i_wr_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (i_rd)
        rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, i_wr} - {1'b0, i_rd};
    end
  end

  assign o_rd_entry = mem_q[rd_ptr_q];
  assign o_occ      = occ_q;

endmodule

// File: rtl/gcbp_line_reader.sv
// gcbp_line_reader: streams stored GCBP sub-image lines from BRAM
// to the matcher over valid/ready, tagged with sub-image and line.
// Ports: i_start kicks a frame; o_bram_en/o_bram_addr/i_bram_data
// read side (1-cycle latency); o_gcbp_line* stream with
// o_hori_subimage_cnt, o_line_cnt, o_last tags; o_busy, o_done.
// Build option: GCBP_BIT_REVERSE_EN bit-reverses o_gcbp_line.
module gcbp_line_reader
  import gcbp_line_reader_pkg::*;
(
  input  logic                        i_clk,
  input  logic                        i_resetn,
  input  logic                        i_start,
  output logic                        o_bram_en,
  output logic [C_BRAM_ADDR_BITS-1:0] o_bram_addr,
  input  logic [C_SUBIMAGE_WIDTH-1:0] i_bram_data,
  output logic [C_SUBIMAGE_WIDTH-1:0] o_gcbp_line,
  output logic                        o_gcbp_line_valid,
  input  logic                        i_gcbp_line_ready,
  output logic [C_SUB_BITS-1:0]       o_hori_subimage_cnt,
  output logic [C_LINE_BITS-1:0]      o_line_cnt,
  output logic                        o_last,
  output logic                        o_busy,
  output logic                        o_done
);

  state_t                      state_q;
  logic [C_BRAM_ADDR_BITS-1:0] rd_cnt_q;
  logic                        ret_q;
  logic [C_BRAM_ADDR_BITS-1:0] ret_addr_q;
  logic                        done_q;

  logic [1:0] occ;
  logic [1:0] load;
  logic       valid;
  logic       pop;
  logic       issue;
  entry_t     head;
  entry_t     wr_entry;

  assign valid = occ != 2'd0;
  assign pop   = valid && i_gcbp_line_ready;

  // Lines that will be held or returning after this edge. A new
  // read is allowed only if its data finds a free slot even when
  // the consumer stalls from now on.
  assign load  = occ - {1'b0, pop} + {1'b0, ret_q};
  assign issue = (state_q == S_READ) && (load < 2'd2);

  always_comb begin
    wr_entry      = '0;
    wr_entry.data = i_bram_data;
    wr_entry.sub  = ret_addr_q[C_BRAM_ADDR_BITS-1 -: C_SUB_BITS];
    wr_entry.line = ret_addr_q[C_LINE_BITS-1:0];
    wr_entry.last = ret_addr_q == C_LAST_ADDR;
  end

  gcbp_rd_fifo2 u_fifo (
    .i_clk      (i_clk),
    .i_resetn   (i_resetn),
    .i_wr       (ret_q),
    .i_wr_entry (wr_entry),
    .i_rd       (pop),
    .o_rd_entry (head),
    .o_occ      (occ)
  );

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q    <= S_IDLE;
      rd_cnt_q   <= '0;
      ret_q      <= 1'b0;
      ret_addr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ret_q  <= issue;
      if (issue)
        ret_addr_q <= rd_cnt_q;
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_q  <= S_READ;
            rd_cnt_q <= '0;
          end
        end
        S_READ: begin
          if (issue) begin
            if (rd_cnt_q == C_LAST_ADDR)
              state_q <= S_DRAIN;
            else
              rd_cnt_q <= rd_cnt_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (load == 2'd0) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_bram_en   = issue;
  assign o_bram_addr = rd_cnt_q;

`ifdef GCBP_BIT_REVERSE_EN
  assign o_gcbp_line = bit_rev(head.data);
`else
  assign o_gcbp_line = head.data;
`endif

  assign o_gcbp_line_valid   = valid;
  assign o_hori_subimage_cnt = head.sub;
  assign o_line_cnt          = head.line;
  assign o_last              = head.last;
  assign o_busy              = state_q != S_IDLE;
  assign o_done              = done_q;

endmodule
